clip_ctrl: RTL and testbench

//  Iterative Cohen-Sutherland line-clip controller, directly upstream of the combinational clip step.

---
 rtl/clip_ctrl_if.sv | 41 ++++
 rtl/clip_ctrl.sv | 120 ++++++++++++
 tb/tb_clip_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clip_ctrl_if.sv
// Bundles the line-clip controller's handshake and data signals.
// Points are packed as {x, y}, each a signed CW-bit coordinate.
//  in_*    : line input (valid/ready) from the upstream producer
//  clip_*  : current endpoints and outcodes to, and results from, the combinational clip step
//  out_*   : clipped line output (valid/ready) to the rasteriser
//  rej_cnt : saturating rejected-line count; iter_ovf: sticky forced-reject flag
// master = controller side, slave = environment side.
interface clip_ctrl_if #(
  parameter int unsigned CW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*CW-1:0] in_p0;
  logic [2*CW-1:0] in_p1;
  logic [2*CW-1:0] clip_p0;
  logic [2*CW-1:0] clip_p1;
  logic [3:0]      clip_oc0;
  logic [3:0]      clip_oc1;
  logic [2*CW-1:0] clip_q0;
  logic [2*CW-1:0] clip_q1;
  logic            clip_accept;
  logic            clip_reject;
  logic            out_valid;
  logic            out_ready;
  logic [2*CW-1:0] out_p0;
  logic [2*CW-1:0] out_p1;
  logic [15:0]     rej_cnt;
  logic            iter_ovf;

  modport master (
    input  in_valid, in_p0, in_p1, clip_q0, clip_q1, clip_accept, clip_reject, out_ready,
    output in_ready, clip_p0, clip_p1, clip_oc0, clip_oc1, out_valid, out_p0, out_p1,
    output rej_cnt, iter_ovf
  );

  modport slave (
    output in_valid, in_p0, in_p1, clip_q0, clip_q1, clip_accept, clip_reject, out_ready,
    input  in_ready, clip_p0, clip_p1, clip_oc0, clip_oc1, out_valid, out_p0, out_p1,
    input  rej_cnt, iter_ovf
  );
endinterface

// File: rtl/clip_ctrl.sv
// Iterative Cohen-Sutherland line-clip controller.
// Takes a line, computes endpoint outcodes, drives the external combinational clip step and
// loops on its results until accept (line emitted downstream) or reject (line dropped, counted).
// Ports:
//  clk   : system clock, rising edge
//  n_rst : asynchronous active-low reset
//  bus   : clip_ctrl_if.master (line in, clip step out/in, clipped line out, status)
module clip_ctrl #(
  parameter int unsigned CW       = 16,
  parameter int          XMIN     = 0,
  parameter int          XMAX     = 639,
  parameter int          YMIN     = 0,
  parameter int          YMAX     = 479,
  parameter int unsigned MAX_ITER = 4
) (
  input logic         clk,
  input logic         n_rst,
  clip_ctrl_if.master bus
);

  localparam int unsigned IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam logic [IW-1:0] IterLast = IW'(MAX_ITER - 1);

  localparam logic [3:0] OcTop    = 4'b1000;
  localparam logic [3:0] OcBottom = 4'b0100;
  localparam logic [3:0] OcRight  = 4'b0010;
  localparam logic [3:0] OcLeft   = 4'b0001;

  typedef enum logic [1:0] {StIdle, StCode, StStep, StOut} state_e;

  state_e          state_q;
  logic [2*CW-1:0] p0_q, p1_q;
  logic [3:0]      oc0_q, oc1_q;
  logic [IW-1:0]   iter_q;
  logic [2*CW-1:0] out_p0_q, out_p1_q;
  logic [15:0]     rej_cnt_q;
  logic            iter_ovf_q;

  function automatic logic [3:0] outcode(input logic [2*CW-1:0] p);
    logic signed [CW-1:0] x, y;
    x = p[2*CW-1:CW];
    y = p[CW-1:0];
    outcode = '0;
    if (int'(y) > YMAX) outcode |= OcTop;
    if (int'(y) < YMIN) outcode |= OcBottom;
    if (int'(x) > XMAX) outcode |= OcRight;
    if (int'(x) < XMIN) outcode |= OcLeft;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      p0_q       <= '0;
      p1_q       <= '0;
      oc0_q      <= '0;
      oc1_q      <= '0;
      iter_q     <= '0;
      out_p0_q   <= '0;
      out_p1_q   <= '0;
      rej_cnt_q  <= '0;
      iter_ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            p0_q    <= bus.in_p0;
            p1_q    <= bus.in_p1;
            iter_q  <= '0;
            state_q <= StCode;
          end
        end
        StCode: begin
          oc0_q   <= outcode(p0_q);
          oc1_q   <= outcode(p1_q);
          state_q <= StStep;
        end
        StStep: begin
          // Reject has priority over accept; forced reject once the pass budget is spent.
          if (bus.clip_reject) begin
            rej_cnt_q <= sat_inc(rej_cnt_q);
            state_q   <= StIdle;
          end else if (bus.clip_accept) begin
            out_p0_q <= bus.clip_q0;
            out_p1_q <= bus.clip_q1;
            state_q  <= StOut;
          end else if (iter_q == IterLast) begin
            rej_cnt_q  <= sat_inc(rej_cnt_q);
            iter_ovf_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            p0_q    <= bus.clip_q0;
            p1_q    <= bus.clip_q1;
            iter_q  <= iter_q + 1'b1;
            state_q <= StCode;
          end
        end
        StOut: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.clip_p0   = p0_q;
  assign bus.clip_p1   = p1_q;
  assign bus.clip_oc0  = oc0_q;
  assign bus.clip_oc1  = oc1_q;
  assign bus.out_p0    = out_p0_q;
  assign bus.out_p1    = out_p1_q;
  assign bus.rej_cnt   = rej_cnt_q;
  assign bus.iter_ovf  = iter_ovf_q;

endmodule

// File: tb/tb_clip_ctrl.sv
module tb_clip_ctrl;
  localparam int XMIN = 0, XMAX = 639, YMIN = 0, YMAX = 479;
  localparam int MAX_ITER = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  clip_ctrl_if #(.CW(16)) bus ();

  clip_ctrl #(
    .CW(16), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkp(input int x, input int y);
    logic [15:0] xs, ys;
    xs = x[15:0];
    ys = y[15:0];
    return {xs, ys};
  endfunction

  function automatic int px(input logic [31:0] p);
    logic signed [15:0] v;
    v = p[31:16];
    return int'(v);
  endfunction

  function automatic int py(input logic [31:0] p);
    logic signed [15:0] v;
    v = p[15:0];
    return int'(v);
  endfunction

  function automatic logic [3:0] ref_oc(input logic [31:0] p);
    ref_oc = 4'b0000;
    if (py(p) > YMAX) ref_oc[3] = 1'b1;
    if (py(p) < YMIN) ref_oc[2] = 1'b1;
    if (px(p) > XMAX) ref_oc[1] = 1'b1;
    if (px(p) < XMIN) ref_oc[0] = 1'b1;
  endfunction

  // Move point p towards other onto the first violated edge (top, bottom, right, left).
  function automatic logic [31:0] clip_pt(input logic [31:0] p, input logic [31:0] o,
                                          input logic [3:0] c);
    int x0, y0, x1, y1, x, y;
    x0 = px(p); y0 = py(p); x1 = px(o); y1 = py(o);
    if (c[3]) begin
      y = YMAX; x = x0 + (x1 - x0) * (YMAX - y0) / (y1 - y0);
    end else if (c[2]) begin
      y = YMIN; x = x0 + (x1 - x0) * (YMIN - y0) / (y1 - y0);
    end else if (c[1]) begin
      x = XMAX; y = y0 + (y1 - y0) * (XMAX - x0) / (x1 - x0);
    end else begin
      x = XMIN; y = y0 + (y1 - y0) * (XMIN - x0) / (x1 - x0);
    end
    return mkp(x, y);
  endfunction

  function automatic void cs_step(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] qa, output logic [31:0] qb,
                                  output logic acc, output logic rej);
    logic [3:0] oa, ob;
    oa = ref_oc(a); ob = ref_oc(b);
    qa = a; qb = b; acc = 1'b0; rej = 1'b0;
    if (oa == 4'b0 && ob == 4'b0) acc = 1'b1;
    else if ((oa & ob) != 4'b0) rej = 1'b1;
    else if (oa != 4'b0) qa = clip_pt(a, b, oa);
    else qb = clip_pt(b, a, ob);
  endfunction

  // Bench clip step: golden single pass, or a stub that never decides and nudges p0 in x.
  bit stub = 1'b0;
  logic [31:0] sq0, sq1;
  logic sacc, srej;
  always_comb begin
    sq0 = '0; sq1 = '0; sacc = 1'b0; srej = 1'b0;
    if (stub) begin
      sq0 = mkp(px(bus.clip_p0) + 1, py(bus.clip_p0));
      sq1 = bus.clip_p1;
    end else begin
      cs_step(bus.clip_p0, bus.clip_p1, sq0, sq1, sacc, srej);
    end
  end
  assign bus.clip_q0     = sq0;
  assign bus.clip_q1     = sq1;
  assign bus.clip_accept = sacc;
  assign bus.clip_reject = srej;

  // Whole-line reference: 0 accept, 1 reject, 2 forced reject; steps = clip-step samples used.
  task automatic predict(input logic [31:0] p0, input logic [31:0] p1, output int kind,
                         output int steps, output logic [31:0] q0, output logic [31:0] q1);
    logic [31:0] a, b, na, nb;
    logic acc, rej;
    a = p0; b = p1; kind = 2; steps = MAX_ITER; q0 = '0; q1 = '0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      cs_step(a, b, na, nb, acc, rej);
      if (rej) begin kind = 1; steps = k; return; end
      if (acc) begin kind = 0; steps = k; q0 = na; q1 = nb; return; end
      a = na; b = nb;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   exp_rej = 0;
  bit   exp_ovf = 1'b0;
  int   last_lat;
  logic [3:0] last_oc0, last_oc1;
  int   last_chg;

  task automatic start_line(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.in_p0 = a; bus.in_p1 = b;
    tick();
    bus.in_valid = 1'b0; bus.in_p0 = '0; bus.in_p1 = '0;
  endtask

  task automatic run_line(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
    int kind, steps, n;
    logic [31:0] q0, q1, prev;
    if (stub) begin kind = 2; steps = MAX_ITER; q0 = '0; q1 = '0; end
    else predict(a, b, kind, steps, q0, q1);
    check({tag, " in_ready idle"}, bus.in_ready, 1);
    start_line(a, b);
    n = 1; last_chg = 0; prev = bus.clip_p0; last_oc0 = 'x; last_oc1 = 'x;
    while (!(bus.out_valid || bus.in_ready) && n < 60) begin
      tick(); n++;
      if (n == 2) begin last_oc0 = bus.clip_oc0; last_oc1 = bus.clip_oc1; end
      if (bus.clip_p0 != prev) last_chg++;
      prev = bus.clip_p0;
    end
    last_lat = n;
    check({tag, " latency"}, n, 1 + 2 * steps);
    check({tag, " out_valid"}, bus.out_valid, (kind == 0) ? 1 : 0);
    if (kind == 0 && bus.out_valid) begin
      for (int h = 0; h < hold; h++) begin
        check({tag, " hold p0"}, bus.out_p0, q0);
        check({tag, " hold p1"}, bus.out_p1, q1);
        check({tag, " hold in_ready"}, bus.in_ready, 0);
        tick();
      end
      check({tag, " out p0"}, bus.out_p0, q0);
      check({tag, " out p1"}, bus.out_p1, q1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, " after handoff in_ready"}, bus.in_ready, 1);
      check({tag, " after handoff out_valid"}, bus.out_valid, 0);
    end
    if (kind != 0) exp_rej++;
    if (kind == 2) exp_ovf = 1'b1;
    check({tag, " rej_cnt"}, bus.rej_cnt, exp_rej);
    check({tag, " iter_ovf"}, bus.iter_ovf, exp_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.in_p0 = '0; bus.in_p1 = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_p0", bus.out_p0, 0);
    check("reset clip_p0", bus.clip_p0, 0);
    check("reset clip_oc0", bus.clip_oc0, 0);
    check("reset rej_cnt", bus.rej_cnt, 0);
    check("reset iter_ovf", bus.iter_ovf, 0);
    #2 n_rst = 1'b1;
    tick();

    run_line("t1 accept", mkp(10, 10), mkp(100, 200), 0);
    check("t1 latency 3", last_lat, 3);

    run_line("t2 reject", mkp(-10, -10), mkp(-5, -20), 0);
    check("t2 oc0", last_oc0, 4'b0101);
    check("t2 oc1", last_oc1, 4'b0101);
    tick();
    check("t2 in_ready at 4", bus.in_ready, 1);
    check("t2 rej_cnt 1", bus.rej_cnt, 1);

    run_line("t3 clip", mkp(-100, 240), mkp(100, 240), 0);
    check("t3 latency 5", last_lat, 5);

    run_line("t4 backpressure", mkp(-50, -50), mkp(700, 500), 10);

    stub = 1'b1;
    run_line("t5 stub", mkp(20, 20), mkp(-30, 30), 0);
    check("t5 step visits", last_chg + 1, 4);
    check("t5 iter_ovf", bus.iter_ovf, 1);
    stub = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = mkp(int'($urandom_range(0, 1400)) - 400, int'($urandom_range(0, 1100)) - 300);
      b = mkp(int'($urandom_range(0, 1400)) - 400, int'($urandom_range(0, 1100)) - 300);
      run_line("rand", a, b, int'($urandom_range(0, 3)));
    end

    // Reset while in STEP.
    start_line(mkp(-100, 240), mkp(100, 240));
    tick();
    n_rst = 1'b0;
    #1;
    check("t6a out_valid", bus.out_valid, 0);
    check("t6a in_ready", bus.in_ready, 1);
    check("t6a clip_p0", bus.clip_p0, 0);
    check("t6a clip_oc0", bus.clip_oc0, 0);
    check("t6a rej_cnt", bus.rej_cnt, 0);
    check("t6a iter_ovf", bus.iter_ovf, 0);
    #2 n_rst = 1'b1;
    exp_rej = 0; exp_ovf = 1'b0;
    tick();
    check("t6a in_ready after release", bus.in_ready, 1);

    // Reset while in OUT.
    start_line(mkp(10, 10), mkp(100, 200));
    tick(); tick();
    check("t6b in OUT", bus.out_valid, 1);
    n_rst = 1'b0;
    #1;
    check("t6b out_valid", bus.out_valid, 0);
    check("t6b out_p0", bus.out_p0, 0);
    check("t6b out_p1", bus.out_p1, 0);
    check("t6b rej_cnt", bus.rej_cnt, 0);
    #2 n_rst = 1'b1;
    tick();
    check("t6b in_ready after release", bus.in_ready, 1);
    run_line("t6 post-reset", mkp(-100, 240), mkp(100, 240), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
